// File: rtl/serv_gen_pkg.sv
// Shared definitions for the SERV state generator: FSM state encoding,
// counter width and the per-width pass length helper.
package serv_gen_pkg;

  localparam int unsigned CNT_W     = 5;
  localparam int unsigned DATA_BITS = 32;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    IDLE  = 3'd1,
    INIT  = 3'd2,
    WAIT  = 3'd3,
    RUN   = 3'd4
  } state_e;

  // Number of cycles in one 32-bit pass for a datapath of w bits per cycle.
  function automatic int unsigned cycles(input int unsigned w);
    return DATA_BITS / w;
  endfunction

endpackage

// File: rtl/serv_pass_cnt.sv
// Pass counter: walks the LSB lane index 0, W, 2W ... 32-W while start is
// high and returns to 0 as soon as start drops.
module serv_pass_cnt
  import serv_gen_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             start,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam int unsigned      CYCLES = cycles(W);
  localparam logic [CNT_W-1:0] STEP   = CNT_W'(W);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'((CYCLES - 1) * W);

  // Lane index register; the step past LAST wraps naturally to 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= cnt + STEP;
    end else begin
      cnt <= '0;
    end
  end

  assign done = start && (cnt == LAST);

endmodule

// File: rtl/serv_state_gen.sv
// SERV instruction state generator: sequences fetch, operand streaming,
// the optional first stage with its wait, and the final run pass.
// Optional feature macro: SERV_STATE_GEN_MDU_EN enables the MDU handshake
// in WAIT; without it o_mdu_valid is tied low and the MDU inputs are ignored.
module serv_state_gen
  import serv_gen_pkg::*;
#(
  parameter int unsigned W        = 1,
  parameter int unsigned WITH_CSR = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ibus_ack,
  output logic             o_ibus_cyc,
  input  logic             i_rf_ready,
  output logic             o_rf_rreq,
  output logic             o_rf_wreq,
  input  logic             i_two_stage_op,
  input  logic             i_take_branch,
  input  logic             i_misalign,
  input  logic             i_wait_done,
  input  logic             i_mdu_op,
  input  logic             i_mdu_ready,
  output logic             o_mdu_valid,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_cnt_en,
  output logic             o_cnt_done,
  output logic             o_init,
  output logic             o_ctrl_jump,
  output logic             o_ctrl_trap
);

  localparam logic CSR_EN = (WITH_CSR != 0);

  state_e state;
  state_e state_nxt;
  logic   stage_one_done;
  logic   cnt_en;
  logic   cnt_done;
  logic   mdu_go;
  logic   wait_exit;

`ifdef SERV_STATE_GEN_MDU_EN
  assign mdu_go = i_mdu_op & i_mdu_ready;
`else
  logic unused_mdu;
  assign unused_mdu = i_mdu_op ^ i_mdu_ready;
  assign mdu_go     = 1'b0;
`endif

  // A latched trap always releases WAIT, whatever the wait sources say.
  assign wait_exit = i_wait_done | mdu_go | o_ctrl_trap;

  serv_pass_cnt #(
    .W (W)
  ) u_pass_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .start (cnt_en),
    .cnt   (o_cnt),
    .done  (cnt_done)
  );

  assign o_cnt_en   = cnt_en;
  assign o_cnt_done = cnt_done;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: if (i_ibus_ack) state_nxt = IDLE;
      IDLE:  if (i_rf_ready) state_nxt = (i_two_stage_op && !stage_one_done) ? INIT : RUN;
      INIT:  if (cnt_done)   state_nxt = WAIT;
      WAIT:  if (wait_exit)  state_nxt = IDLE;
      RUN:   if (cnt_done)   state_nxt = FETCH;
      default:               state_nxt = FETCH;
    endcase
  end

  // State-decoded outputs and handshake pulses.
  always_comb begin
    o_ibus_cyc  = 1'b0;
    o_rf_rreq   = 1'b0;
    o_rf_wreq   = 1'b0;
    o_mdu_valid = 1'b0;
    o_init      = 1'b0;
    cnt_en      = 1'b0;
    case (state)
      FETCH: begin
        o_ibus_cyc = 1'b1;
        o_rf_rreq  = i_ibus_ack;
      end
      INIT: begin
        cnt_en = 1'b1;
        o_init = 1'b1;
      end
      WAIT: begin
        o_rf_wreq = wait_exit;
`ifdef SERV_STATE_GEN_MDU_EN
        o_mdu_valid = i_mdu_op;
`endif
      end
      RUN:     cnt_en = 1'b1;
      default: ;
    endcase
  end

  // Control flags: captured at the end of stage one, dropped after the run.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ctrl_jump    <= 1'b0;
      o_ctrl_trap    <= 1'b0;
      stage_one_done <= 1'b0;
    end else begin
      if (state == INIT && cnt_done) begin
        o_ctrl_jump <= i_take_branch;
        o_ctrl_trap <= CSR_EN & i_misalign;
      end
      if (state == WAIT && wait_exit) begin
        stage_one_done <= 1'b1;
      end
      if (state == RUN && cnt_done) begin
        o_ctrl_jump    <= 1'b0;
        o_ctrl_trap    <= 1'b0;
        stage_one_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serv_state_gen.sv
// Self-checking bench for serv_state_gen: one DUT lane per datapath width
// (W = 1, 4, 2, 8), each running the same instruction program. A per-lane
// monitor summarises every instruction and compares it against the
// expectation queued by the driver when the instruction was issued.
`timescale 1ns/1ps
module tb_serv_state_gen;

  localparam int NL  = 4;
  localparam int TMO = 300;

`ifdef SERV_STATE_GEN_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  typedef struct {
    bit two;
    bit br;
    bit mis;
    bit mdu;
    int wdelay;
    int mdelay;
  } instr_t;

  typedef struct {
    int init_c;
    int run_c;
    int rreq;
    int wreq;
    int mdu_c;
    int jump_c;
    int trap_c;
    int bad;
  } obs_t;

  logic clk = 1'b0;
  int   nchecks = 0;
  int   nfail   = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    nchecks++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cmp_obs(input string p, input obs_t g, input obs_t e);
    check({p, "_init_len"}, g.init_c, e.init_c);
    check({p, "_run_len"},  g.run_c,  e.run_c);
    check({p, "_rreq"},     g.rreq,   e.rreq);
    check({p, "_wreq"},     g.wreq,   e.wreq);
    check({p, "_mdu_vld"},  g.mdu_c,  e.mdu_c);
    check({p, "_jump"},     g.jump_c, e.jump_c);
    check({p, "_trap"},     g.trap_c, e.trap_c);
    check({p, "_cnt_seq"},  g.bad,    e.bad);
  endtask

  // Instruction program shared by all lanes.
  function automatic instr_t prog(input int i);
    instr_t t;
    t = '{two: 1'b0, br: 1'b0, mis: 1'b0, mdu: 1'b0, wdelay: -1, mdelay: -1};
    case (i)
      1: begin t.two = 1'b1; t.br = 1'b1; t.wdelay = 0; end
      2: begin t.two = 1'b1; t.wdelay = 5; end
      3: begin t.two = 1'b1; t.mis = 1'b1; end
      4: begin t.two = 1'b1; t.mis = 1'b1; t.wdelay = 0; end
      5: begin t.two = 1'b1; t.mdu = 1'b1; t.mdelay = 3; t.wdelay = 6; end
      6: begin t.two = 1'b1; t.wdelay = 2; end
      default: ;
    endcase
    return t;
  endfunction

  // Transaction-level expectation for one instruction.
  function automatic obs_t expect_of(input instr_t t, input int cyc);
    obs_t e;
    e.init_c = t.two ? cyc : 0;
    e.run_c  = cyc;
    e.rreq   = 1;
    e.wreq   = t.two ? 1 : 0;
    e.mdu_c  = (MDU_EN && t.two && t.mdu) ? t.mdelay + 1 : 0;
    e.jump_c = (t.two && t.br)  ? cyc : 0;
    e.trap_c = (t.two && t.mis) ? cyc : 0;
    e.bad    = 0;
    return e;
  endfunction

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int unsigned LW     = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 2 : 8;
    localparam int          CYC    = 32 / LW;
    localparam int          RST_AT = (LW == 8) ? 16 : 12;

    logic       rst, ibus_ack, rf_ready, two, br, mis, wait_done, mdu_op, mdu_ready;
    logic       ibus_cyc, rf_rreq, rf_wreq, mdu_valid, cnt_en, cnt_done, init, jump, trap;
    logic [4:0] cnt;
    logic       done_l = 1'b0;
    obs_t       exp_q[$];
    obs_t       acc;
    obs_t       e_pop;
    int         idx = 0;

    serv_state_gen #(
      .W        (LW),
      .WITH_CSR (1)
    ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_ibus_ack     (ibus_ack),
      .o_ibus_cyc     (ibus_cyc),
      .i_rf_ready     (rf_ready),
      .o_rf_rreq      (rf_rreq),
      .o_rf_wreq      (rf_wreq),
      .i_two_stage_op (two),
      .i_take_branch  (br),
      .i_misalign     (mis),
      .i_wait_done    (wait_done),
      .i_mdu_op       (mdu_op),
      .i_mdu_ready    (mdu_ready),
      .o_mdu_valid    (mdu_valid),
      .o_cnt          (cnt),
      .o_cnt_en       (cnt_en),
      .o_cnt_done     (cnt_done),
      .o_init         (init),
      .o_ctrl_jump    (jump),
      .o_ctrl_trap    (trap)
    );

    function automatic string tag(input string s);
      return $sformatf("W%0d_%s", LW, s);
    endfunction

    // Monitor: accumulate per-instruction activity, compare at end of RUN.
    always @(negedge clk) begin
      #2;
      if (rst) begin
        acc = '{default: 0};
        idx = 0;
      end else begin
        if (cnt_en) begin
          if (cnt != 5'(idx * LW) || cnt_done != (idx == CYC - 1)) acc.bad++;
          idx++;
          if (init) begin
            acc.init_c++;
          end else begin
            acc.run_c++;
            if (jump) acc.jump_c++;
            if (trap) acc.trap_c++;
          end
        end else begin
          if (cnt != 5'd0 || cnt_done) acc.bad++;
          idx = 0;
        end
        if (rf_rreq)   acc.rreq++;
        if (rf_wreq)   acc.wreq++;
        if (mdu_valid) acc.mdu_c++;
        if (cnt_en && !init && cnt_done) begin
          if (exp_q.size() == 0) begin
            check(tag("sb_empty"), 1, 0);
          end else begin
            e_pop = exp_q.pop_front();
            cmp_obs(tag("sb"), acc, e_pop);
          end
          acc = '{default: 0};
        end
      end
    end

    // Drive one instruction from FETCH back to the next FETCH.
    task automatic do_instr(input instr_t t);
      int n;
      exp_q.push_back(expect_of(t, CYC));
      two = t.two; br = t.br; mis = t.mis; mdu_op = t.mdu;
      n = 0;
      while (!ibus_cyc && n < TMO) begin @(negedge clk); n++; end
      if (n >= TMO) check(tag("fetch_tmo"), 0, 1);
      rf_ready = 1'b1;
      @(negedge clk);
      rf_ready = 1'b0;
      check(tag("stray_rdy"), ibus_cyc, 1);
      ibus_ack = 1'b1;
      @(negedge clk);
      ibus_ack = 1'b0;
      rf_ready = 1'b1;
      @(negedge clk);
      rf_ready = 1'b0;
      if (t.two) begin
        n = 0;
        while (init && n < TMO) begin @(negedge clk); n++; end
        n = 0;
        while (n < TMO) begin
          if (n == t.wdelay) wait_done = 1'b1;
          if (n == t.mdelay) mdu_ready = 1'b1;
          #1;
          if (rf_wreq) break;
          @(negedge clk);
          n++;
        end
        if (n >= TMO) check(tag("wait_tmo"), 0, 1);
        @(negedge clk);
        wait_done = 1'b0;
        mdu_ready = 1'b0;
        rf_ready  = 1'b1;
        @(negedge clk);
        rf_ready = 1'b0;
      end
      ibus_ack = 1'b1;
      @(negedge clk);
      ibus_ack = 1'b0;
      n = 1;
      while (!ibus_cyc && n < TMO) begin @(negedge clk); n++; end
      check(tag("run_to_fetch"), n, CYC);
      check(tag("flags_clr"), int'({jump, trap}), 0);
    endtask

    // Abort a first-stage pass with reset part way through INIT.
    task automatic reset_mid_init();
      int n;
      int wr;
      two = 1'b1; br = 1'b1; mis = 1'b1; mdu_op = 1'b0;
      ibus_ack = 1'b1;
      @(negedge clk);
      ibus_ack = 1'b0;
      rf_ready = 1'b1;
      @(negedge clk);
      rf_ready = 1'b0;
      n = 0;
      while (int'(cnt) != RST_AT && n < TMO) begin @(negedge clk); n++; end
      check(tag("rst_in_init"), int'(init), 1);
      rst = 1'b1;
      wr  = 0;
      repeat (2) begin
        #1;
        wr += int'(rf_wreq);
        @(negedge clk);
      end
      rst = 1'b0;
      #1;
      check(tag("rst_wreq"),  wr, 0);
      check(tag("rst_cnt"),   int'(cnt), 0);
      check(tag("rst_cnten"), int'(cnt_en), 0);
      check(tag("rst_flags"), int'({jump, trap}), 0);
      check(tag("rst_fetch"), int'(ibus_cyc), 1);
      @(negedge clk);
    endtask

    initial begin
      rst = 1'b1; ibus_ack = 1'b0; rf_ready = 1'b0; two = 1'b0; br = 1'b0;
      mis = 1'b0; wait_done = 1'b0; mdu_op = 1'b0; mdu_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check(tag("por_cnt"),   int'(cnt), 0);
      check(tag("por_cnten"), int'(cnt_en), 0);
      check(tag("por_flags"), int'({jump, trap}), 0);
      check(tag("por_fetch"), int'(ibus_cyc), 1);
      check(tag("por_wreq"),  int'(rf_wreq), 0);
      check(tag("por_mdu"),   int'(mdu_valid), 0);
      @(negedge clk);
      for (int i = 0; i < 7; i++) do_instr(prog(i));
      reset_mid_init();
      do_instr(prog(1));
      do_instr(prog(0));
      repeat (2) @(negedge clk);
      check(tag("sb_drain"), exp_q.size(), 0);
      done_l = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(lane[0].done_l && lane[1].done_l && lane[2].done_l && lane[3].done_l) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 20000) check("global_tmo", 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/serv_state_gen.md
SERV_STATE_GEN -- requirements
Module: serv_state_gen

Interface
REQ-001 SHALL have parameter W, default 1, giving datapath bits per cycle; legal values are 1, 2, 4 and 8.
REQ-002 SHALL have parameter WITH_CSR, default 1; when 1, misalignment traps are enabled.
REQ-003 SHALL have port i_clk, input, 1 bit, the clock.
REQ-004 SHALL have port i_rst, input, 1 bit; reset is i_rst, synchronous, active-high, on clock i_clk.
REQ-005 SHALL have port i_ibus_ack, input, 1 bit, instruction fetch acknowledge.
REQ-006 SHALL have port o_ibus_cyc, output, 1 bit, instruction fetch request.
REQ-007 SHALL have port i_rf_ready, input, 1 bit, register file ready to stream operands.
REQ-008 SHALL have port o_rf_rreq, output, 1 bit, register file read request.
REQ-009 SHALL have port o_rf_wreq, output, 1 bit, register file write request.
REQ-010 SHALL have port i_two_stage_op, input, 1 bit, marking a two-stage instruction (branch/mem/shift/slt/mdu).
REQ-011 SHALL have port i_take_branch, input, 1 bit, branch taken; valid in the last INIT cycle.
REQ-012 SHALL have port i_misalign, input, 1 bit, misaligned branch or memory access; valid in the last INIT cycle.
REQ-013 SHALL have port i_wait_done, input, 1 bit, completion of a dbus, shift or slt wait.
REQ-014 SHALL have port i_mdu_op, input, 1 bit, marking an MDU instruction.
REQ-015 SHALL have port i_mdu_ready, input, 1 bit, MDU result ready.
REQ-016 SHALL have port o_mdu_valid, output, 1 bit, MDU start request.
REQ-017 SHALL have port o_cnt, output, 5 bits, bit index of the current LSB lane.
REQ-018 SHALL have port o_cnt_en, output, 1 bit, high while a 32-bit pass is streaming.
REQ-019 SHALL have port o_cnt_done, output, 1 bit, high in the last cycle of a pass.
REQ-020 SHALL have port o_init, output, 1 bit, high while the current pass is stage one.
REQ-021 SHALL have port o_ctrl_jump, output, 1 bit, registered branch-taken flag.
REQ-022 SHALL have port o_ctrl_trap, output, 1 bit, registered misalignment trap flag.

Function
REQ-023 SHALL implement the FSM states FETCH, IDLE, INIT, WAIT and RUN.
REQ-024 SHALL, in FETCH, hold o_ibus_cyc=1; on i_ibus_ack it pulses o_rf_rreq for 1 cycle and moves to IDLE.
REQ-025 SHALL, in IDLE, move on i_rf_ready to INIT when i_two_stage_op and stage one is not yet done; otherwise it moves to RUN.
REQ-026 SHALL make each pass (INIT or RUN) last exactly 32/W cycles, with o_cnt stepping 0, W, 2W, ... up to 32-W.
REQ-027 SHALL assert o_cnt_done combinationally when o_cnt==32-W and o_cnt_en=1.
REQ-028 SHALL, at INIT o_cnt_done, latch o_ctrl_jump<=i_take_branch and o_ctrl_trap<=WITH_CSR&i_misalign, then enter WAIT.
REQ-029 SHALL, in WAIT, drive o_mdu_valid=i_mdu_op for as long as it stays in WAIT.
REQ-030 SHALL leave WAIT when i_wait_done, (i_mdu_op & i_mdu_ready) or o_ctrl_trap is true; in that cycle it pulses o_rf_wreq for 1 cycle and moves to IDLE with stage one marked done.
REQ-031 SHALL, at RUN o_cnt_done, clear the stage-one-done flag, o_ctrl_jump and o_ctrl_trap, then enter FETCH.
REQ-032 SHALL give a single-stage instruction the sequence FETCH, IDLE, RUN, FETCH with no WAIT.
REQ-033 SHALL treat simultaneous i_wait_done and a latched trap as a trap; exactly one o_rf_wreq pulse results.
REQ-034 SHALL ignore i_rf_ready outside IDLE and i_ibus_ack outside FETCH.
REQ-035 SHALL derive o_cnt_en=(state==INIT|state==RUN) and o_init=(state==INIT).
REQ-036 SHALL hold o_cnt at 0 outside INIT and RUN.

Reset
REQ-037 SHALL, on i_rst, enter FETCH with o_cnt=0, o_ctrl_jump=0, o_ctrl_trap=0 and stage-one-done=0.
REQ-038 SHALL assert o_ibus_cyc in the first cycle after i_rst deasserts.
REQ-039 SHALL abort any pass in progress when i_rst is asserted mid-pass, producing no o_rf_wreq.

Configuration
REQ-040 SHALL support the macro SERV_STATE_GEN_MDU_EN; when it is defined, REQ-029 and REQ-030 apply in full.
REQ-041 SHALL, without SERV_STATE_GEN_MDU_EN, tie o_mdu_valid to 0 and ignore i_mdu_op and i_mdu_ready.

Structure
REQ-042 SHALL take the state enum and the per-W cycle count CYCLES=32/W from a shared package, serv_gen_pkg.
REQ-043 SHALL place the pass counter in one sub-module, serv_pass_cnt, with inputs start and W and outputs cnt and done.

Verification
REQ-044 SHALL cover: W=1, single-stage add; i_rf_ready -> RUN lasts 32 cycles, o_cnt_done on cycle 32, o_ibus_cyc rises the cycle after.
REQ-045 SHALL cover: W=4, branch with i_take_branch=1 -> INIT lasts 8 cycles, o_ctrl_jump=1 through RUN, then cleared.
REQ-046 SHALL cover: W=2, load with i_wait_done arriving 5 cycles into WAIT -> one o_rf_wreq pulse, RUN lasts 16 cycles.
REQ-047 SHALL cover: W=8, i_misalign=1 -> o_ctrl_trap=1, WAIT exits next cycle with no i_wait_done, RUN lasts 4 cycles.
REQ-048 SHALL cover: MDU macro defined, i_mdu_op=1 -> o_mdu_valid held until i_mdu_ready=1; macro undefined -> o_mdu_valid stays 0.
REQ-049 SHALL cover: i_rst asserted at o_cnt=12 of INIT -> FETCH with no o_rf_wreq, and o_ibus_cyc=1 after release.
